// File: rtl/pcie_tx_arbiter.sv
// Purpose: per-TLP round-robin merge of PIO engine (req/ack) and inject streams onto the PCIe core TX port.
// Latency: grant 1 cycle after request; beat on pcie_tx1_* 1 cycle after acceptance when the skid is empty.
// Backpressure: 2-entry skid; source readies come from a registered not-full flag, no path from core tready.
module pcie_tx_arbiter #(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
   input  logic                    pcie_clk,
   input  logic                    pcie_rst_n,
   // PIO engine
   input  logic                    pcie_tx_req,
   output logic                    pcie_tx_ack,
   output logic                    pcie_tx_tready,
   input  logic                    pcie_tx_tvalid,
   input  logic                    pcie_tx_tlast,
   input  logic [KEEP_WIDTH-1:0]   pcie_tx_tkeep,
   input  logic [C_DATA_WIDTH-1:0] pcie_tx_tdata,
   input  logic [3:0]              pcie_tx_tuser,
   // Ethernet inject stream
   output logic                    inj_tx_tready,
   input  logic                    inj_tx_tvalid,
   input  logic                    inj_tx_tlast,
   input  logic [KEEP_WIDTH-1:0]   inj_tx_tkeep,
   input  logic [C_DATA_WIDTH-1:0] inj_tx_tdata,
   input  logic [3:0]              inj_tx_tuser,
   // PCIe core TX
   input  logic                    pcie_tx1_tready,
   output logic                    pcie_tx1_tvalid,
   output logic                    pcie_tx1_tlast,
   output logic [KEEP_WIDTH-1:0]   pcie_tx1_tkeep,
   output logic [C_DATA_WIDTH-1:0] pcie_tx1_tdata,
   output logic [3:0]              pcie_tx1_tuser,
   // statistics
   output logic [31:0]             tx_app_cnt,
   output logic [31:0]             tx_inj_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      APP  = 2'd1,
      INJ  = 2'd2
   } state_t;

   typedef struct packed {
      logic [C_DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0]   keep;
      logic [3:0]              user;
      logic                    last;
   } beat_t;

   state_t      state;
   logic        last_inj;      // last_grant: 1 = INJ, 0 = APP
   logic        not_full;
   logic        app_acc;
   logic        inj_acc;
   logic        push;
   logic        pop;
   beat_t       push_beat;
   beat_t       head;
   beat_t       skid [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  cnt;
   logic [1:0]  cnt_nxt;

   // Source readies depend only on registered state, never on the core's tready.
   assign pcie_tx_tready = (state == APP) && not_full;
   assign inj_tx_tready  = (state == INJ) && not_full;
   assign app_acc        = pcie_tx_tvalid && pcie_tx_tready;
   assign inj_acc        = inj_tx_tvalid && inj_tx_tready;
   assign push           = app_acc || inj_acc;
   assign pop            = (cnt != 2'd0) && pcie_tx1_tready;

   // Select the beat being written into the skid from the current owner.
   always_comb begin
      push_beat = '0;
      if (state == APP) begin
         push_beat.data = pcie_tx_tdata;
         push_beat.keep = pcie_tx_tkeep;
         push_beat.user = pcie_tx_tuser;
         push_beat.last = pcie_tx_tlast;
      end else begin
         push_beat.data = inj_tx_tdata;
         push_beat.keep = inj_tx_tkeep;
         push_beat.user = inj_tx_tuser;
         push_beat.last = inj_tx_tlast;
      end
   end

   // Arbitration FSM: ownership changes only in IDLE, released on an accepted tlast beat.
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         state       <= IDLE;
         last_inj    <= 1'b1;
         pcie_tx_ack <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pcie_tx_req && (!inj_tx_tvalid || last_inj)) begin
                  state       <= APP;
                  last_inj    <= 1'b0;
                  pcie_tx_ack <= 1'b1;
               end else if (inj_tx_tvalid) begin
                  state    <= INJ;
                  last_inj <= 1'b1;
               end
            end
            APP: begin
               // A dropped request mid-TLP is ignored; only tlast ends ownership.
               if (app_acc && pcie_tx_tlast) begin
                  state       <= IDLE;
                  pcie_tx_ack <= 1'b0;
               end
            end
            INJ: begin
               if (inj_acc && inj_tx_tlast) begin
                  state <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               pcie_tx_ack <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_nxt = cnt + 2'(push) - 2'(pop);

   // Two-entry skid: ring of two slots, registered occupancy and not-full flag.
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         skid[0]  <= '0;
         skid[1]  <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         cnt      <= 2'd0;
         not_full <= 1'b1;
      end else begin
         if (push) begin
            skid[wr_ptr] <= push_beat;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt      <= cnt_nxt;
         not_full <= (cnt_nxt != 2'd2);
      end
   end

   // The head slot only moves on a pop, so outputs hold while the core stalls.
   assign head            = skid[rd_ptr];
   assign pcie_tx1_tvalid = (cnt != 2'd0);
   assign pcie_tx1_tdata  = head.data;
   assign pcie_tx1_tkeep  = head.keep;
   assign pcie_tx1_tuser  = head.user;
   assign pcie_tx1_tlast  = head.last;

   // Per-source TLP counters, bumped when the tlast beat is taken from the source.
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         tx_app_cnt <= 32'd0;
         tx_inj_cnt <= 32'd0;
      end else begin
         if (app_acc && pcie_tx_tlast) begin
            tx_app_cnt <= tx_app_cnt + 32'd1;
         end
         if (inj_acc && inj_tx_tlast) begin
            tx_inj_cnt <= tx_inj_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed scenarios plus randomized traffic.
// Reference: per-source expected-beat queues, packet-order log and TLP counts.
// Core tready is fixed or randomized by a single driver process.
module tb_pcie_tx_arbiter;

   localparam int DW = 64;
   localparam int KW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [3:0]    user;
      logic          last;
   } beat_t;

   logic          pcie_clk = 1'b0;
   logic          pcie_rst_n;
   logic          pcie_tx_req, pcie_tx_ack, pcie_tx_tready, pcie_tx_tvalid, pcie_tx_tlast;
   logic [KW-1:0] pcie_tx_tkeep;
   logic [DW-1:0] pcie_tx_tdata;
   logic [3:0]    pcie_tx_tuser;
   logic          inj_tx_tready, inj_tx_tvalid, inj_tx_tlast;
   logic [KW-1:0] inj_tx_tkeep;
   logic [DW-1:0] inj_tx_tdata;
   logic [3:0]    inj_tx_tuser;
   logic          pcie_tx1_tready, pcie_tx1_tvalid, pcie_tx1_tlast;
   logic [KW-1:0] pcie_tx1_tkeep;
   logic [DW-1:0] pcie_tx1_tdata;
   logic [3:0]    pcie_tx1_tuser;
   logic [31:0]   tx_app_cnt, tx_inj_cnt;

   // reference model state
   beat_t       exp_q0[$];
   beat_t       exp_q1[$];
   int          order_q[$];
   logic [31:0] app_cnt_exp = 32'd0;
   logic [31:0] inj_cnt_exp = 32'd0;
   int          cur_src = -1;

   int errors = 0;
   int checks = 0;
   bit fixed_rdy = 1'b1;
   bit rnd_rdy = 1'b0;

   always #5 pcie_clk = ~pcie_clk;

   pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
      .pcie_tx_req(pcie_tx_req), .pcie_tx_ack(pcie_tx_ack), .pcie_tx_tready(pcie_tx_tready),
      .pcie_tx_tvalid(pcie_tx_tvalid), .pcie_tx_tlast(pcie_tx_tlast), .pcie_tx_tkeep(pcie_tx_tkeep),
      .pcie_tx_tdata(pcie_tx_tdata), .pcie_tx_tuser(pcie_tx_tuser),
      .inj_tx_tready(inj_tx_tready), .inj_tx_tvalid(inj_tx_tvalid), .inj_tx_tlast(inj_tx_tlast),
      .inj_tx_tkeep(inj_tx_tkeep), .inj_tx_tdata(inj_tx_tdata), .inj_tx_tuser(inj_tx_tuser),
      .pcie_tx1_tready(pcie_tx1_tready), .pcie_tx1_tvalid(pcie_tx1_tvalid), .pcie_tx1_tlast(pcie_tx1_tlast),
      .pcie_tx1_tkeep(pcie_tx1_tkeep), .pcie_tx1_tdata(pcie_tx1_tdata), .pcie_tx1_tuser(pcie_tx1_tuser),
      .tx_app_cnt(tx_app_cnt), .tx_inj_cnt(tx_inj_cnt)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pcie_clk);
      #1;
   endtask

   task automatic drive(input bit src, input bit vld, input beat_t b);
      if (!src) begin
         pcie_tx_tvalid = vld;
         pcie_tx_tdata  = b.data;
         pcie_tx_tkeep  = b.keep;
         pcie_tx_tuser  = b.user;
         pcie_tx_tlast  = b.last;
      end else begin
         inj_tx_tvalid = vld;
         inj_tx_tdata  = b.data;
         inj_tx_tkeep  = b.keep;
         inj_tx_tuser  = b.user;
         inj_tx_tlast  = b.last;
      end
   endtask

   // Sends one TLP; beat i carries base*(i+1) with bit 63 marking the source.
   // stop < nb abandons the TLP after that many accepted beats.
   task automatic send_tlp(input bit src, input int nb, input logic [63:0] base,
                           input bit hold, input bit drop, input bit gaps, input int stop);
      beat_t b;
      bit    acc;
      int    guard;
      int    n;
      if (!src) pcie_tx_req = 1'b1;
      for (int i = 0; i < nb; i++) begin
         b.data     = base * 64'(i + 1);
         b.data[63] = src;
         b.keep     = 8'($urandom());
         b.user     = 4'($urandom());
         b.last     = (i == nb - 1);
         drive(src, 1'b1, b);
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 300) begin
            @(negedge pcie_clk);
            acc = src ? inj_tx_tready : pcie_tx_tready;
            if (drop && i > 0) begin
               check("ack_hold", pcie_tx_ack, 1);
               check("inj_blocked", inj_tx_tready, 0);
            end
            step();
            guard++;
         end
         if (!acc) begin
            check("handshake_timeout", 0, 1);
            drive(src, 1'b0, '0);
            if (!src) pcie_tx_req = 1'b0;
            return;
         end
         if (src) exp_q1.push_back(b);
         else     exp_q0.push_back(b);
         if (b.last) begin
            if (src) inj_cnt_exp++;
            else     app_cnt_exp++;
         end
         if (drop && i == 0) pcie_tx_req = 1'b0;
         if (stop < nb && i + 1 == stop) begin
            drive(src, 1'b0, '0);
            return;
         end
         if (gaps && !b.last) begin
            n = $urandom_range(0, 2);
            if (n > 0) drive(src, 1'b0, b);
            repeat (n) step();
         end
      end
      drive(src, 1'b0, '0);
      if (!src && !hold) pcie_tx_req = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || pcie_tx1_tvalid) && g < 500) begin
         step();
         g++;
      end
      if (g >= 500) check("drain_timeout", 0, 1);
   endtask

   // Single driver of the core-side ready: fixed level or random.
   initial begin
      pcie_tx1_tready = 1'b0;
      forever begin
         @(posedge pcie_clk);
         #1;
         pcie_tx1_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
      end
   end

   // Output scoreboard: each packet must match its source's next expected beats in order.
   always @(negedge pcie_clk) begin
      beat_t g;
      beat_t e;
      int    src;
      if (pcie_rst_n && pcie_tx1_tvalid && pcie_tx1_tready) begin
         g.data = pcie_tx1_tdata;
         g.keep = pcie_tx1_tkeep;
         g.user = pcie_tx1_tuser;
         g.last = pcie_tx1_tlast;
         src = (cur_src < 0) ? int'(pcie_tx1_tdata[63]) : cur_src;
         if ((src == 0 && exp_q0.size() == 0) || (src == 1 && exp_q1.size() == 0)) begin
            check("unexpected_beat", g, 0);
         end else begin
            e = (src == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("beat", g, e);
         end
         if (g.last) begin
            order_q.push_back(src);
            cur_src = -1;
         end else begin
            cur_src = src;
         end
      end
   end

   initial begin
      int exp_order[4];
      logic [63:0] d0;
      exp_order = '{0, 1, 0, 1};
      pcie_rst_n  = 1'b0;
      pcie_tx_req = 1'b0;
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);

      // reset values
      #12;
      check("rst_tx1_tvalid", pcie_tx1_tvalid, 0);
      check("rst_tx1_tdata", pcie_tx1_tdata, 0);
      check("rst_tx1_tlast", pcie_tx1_tlast, 0);
      check("rst_tx1_tkeep", {pcie_tx1_tkeep, pcie_tx1_tuser}, 0);
      check("rst_ack", pcie_tx_ack, 0);
      check("rst_readies", {pcie_tx_tready, inj_tx_tready}, 0);
      check("rst_app_cnt", tx_app_cnt, 0);
      check("rst_inj_cnt", tx_inj_cnt, 0);
      @(negedge pcie_clk);
      pcie_rst_n = 1'b1;

      // simultaneous requests from reset: APP, INJ, APP, INJ
      step();
      fork
         begin
            send_tlp(1'b0, 2, 64'h100, 1'b1, 1'b0, 1'b0, 2);
            send_tlp(1'b0, 2, 64'h200, 1'b0, 1'b0, 1'b0, 2);
         end
         begin
            send_tlp(1'b1, 2, 64'h300, 1'b0, 1'b0, 1'b0, 2);
            send_tlp(1'b1, 2, 64'h400, 1'b0, 1'b0, 1'b0, 2);
         end
      join
      drain();
      check("rr_order_len", order_q.size(), 4);
      for (int i = 0; i < 4; i++)
         check("rr_order", (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);
      check("rr_app_cnt", tx_app_cnt, app_cnt_exp);
      check("rr_inj_cnt", tx_inj_cnt, inj_cnt_exp);
      order_q.delete();

      // single PIO TLP with cycle-level timing
      step();
      fork
         send_tlp(1'b0, 3, 64'h11, 1'b0, 1'b0, 1'b0, 3);
         begin
            @(negedge pcie_clk);
            check("pio_ack_pre", pcie_tx_ack, 0);
            @(negedge pcie_clk);
            check("pio_ack_rise", pcie_tx_ack, 1);
            check("pio_tready", pcie_tx_tready, 1);
            check("pio_out_empty", pcie_tx1_tvalid, 0);
            @(negedge pcie_clk);
            check("pio_beat1_vld", pcie_tx1_tvalid, 1);
            check("pio_beat1", pcie_tx1_tdata, 64'h11);
            @(negedge pcie_clk);
            check("pio_beat2", pcie_tx1_tdata, 64'h22);
            @(negedge pcie_clk);
            check("pio_ack_fall", pcie_tx_ack, 0);
            check("pio_beat3", {pcie_tx1_tdata, pcie_tx1_tlast}, {64'h33, 1'b1});
            check("pio_app_cnt", tx_app_cnt, app_cnt_exp);
         end
      join
      drain();
      order_q.delete();

      // request dropped mid-TLP; inject waits for tlast
      step();
      fork
         send_tlp(1'b0, 3, 64'h5000, 1'b0, 1'b1, 1'b0, 3);
         begin
            step();
            step();
            send_tlp(1'b1, 2, 64'h6000, 1'b0, 1'b0, 1'b0, 2);
         end
      join
      drain();
      check("drop_order_len", order_q.size(), 2);
      if (order_q.size() == 2) begin
         check("drop_first", order_q[0], 0);
         check("drop_second", order_q[1], 1);
      end
      order_q.delete();

      // counter wrap
      @(negedge pcie_clk);
      force dut.tx_inj_cnt = 32'hFFFF_FFFF;
      @(negedge pcie_clk);
      release dut.tx_inj_cnt;
      inj_cnt_exp = 32'hFFFF_FFFF;
      step();
      send_tlp(1'b1, 1, 64'h77, 1'b0, 1'b0, 1'b0, 1);
      drain();
      check("inj_cnt_wrap", tx_inj_cnt, inj_cnt_exp);
      check("inj_cnt_zero", tx_inj_cnt, 32'd0);
      order_q.delete();

      // backpressure during a 4-beat inject TLP
      @(negedge pcie_clk);
      fixed_rdy = 1'b0;
      step();
      d0 = 64'hBB;
      d0[63] = 1'b1;
      fork
         send_tlp(1'b1, 4, 64'hBB, 1'b0, 1'b0, 1'b0, 4);
         begin
            @(negedge pcie_clk);
            @(negedge pcie_clk);
            @(negedge pcie_clk);
            check("bp_head", pcie_tx1_tdata, d0);
            for (int k = 4; k <= 6; k++) begin
               @(negedge pcie_clk);
               if (k == 4) check("bp_accepted", exp_q1.size(), 2);
               check("bp_inj_tready", inj_tx_tready, 0);
               check("bp_hold", {pcie_tx1_tvalid, pcie_tx1_tdata, pcie_tx1_tlast}, {1'b1, d0, 1'b0});
            end
            fixed_rdy = 1'b1;
         end
      join
      drain();
      check("bp_inj_cnt", tx_inj_cnt, inj_cnt_exp);
      order_q.delete();

      // randomized traffic with random core backpressure
      @(negedge pcie_clk);
      rnd_rdy = 1'b1;
      step();
      fork
         repeat (12) begin
            repeat ($urandom_range(0, 3)) step();
            send_tlp(1'b0, $urandom_range(1, 5), 64'($urandom()), 1'b0, 1'b0, 1'b1, 8);
         end
         repeat (12) begin
            repeat ($urandom_range(0, 3)) step();
            send_tlp(1'b1, $urandom_range(1, 5), 64'($urandom()), 1'b0, 1'b0, 1'b1, 8);
         end
      join
      @(negedge pcie_clk);
      rnd_rdy = 1'b0;
      drain();
      check("rnd_app_cnt", tx_app_cnt, app_cnt_exp);
      check("rnd_inj_cnt", tx_inj_cnt, inj_cnt_exp);
      check("rnd_tlps", order_q.size(), 24);
      order_q.delete();

      // reset in the middle of a 4-beat inject TLP
      @(negedge pcie_clk);
      fixed_rdy = 1'b0;
      step();
      send_tlp(1'b1, 4, 64'hCC, 1'b0, 1'b0, 1'b0, 2);
      pcie_rst_n = 1'b0;
      #1;
      check("arst_tx1", {pcie_tx1_tvalid, pcie_tx1_tlast, pcie_tx1_tdata, pcie_tx1_tkeep, pcie_tx1_tuser}, 0);
      check("arst_ctrl", {pcie_tx_ack, pcie_tx_tready, inj_tx_tready}, 0);
      check("arst_cnts", {tx_app_cnt, tx_inj_cnt}, 0);
      exp_q0.delete();
      exp_q1.delete();
      order_q.delete();
      cur_src = -1;
      app_cnt_exp = 32'd0;
      inj_cnt_exp = 32'd0;
      @(negedge pcie_clk);
      fixed_rdy = 1'b1;
      pcie_rst_n = 1'b1;
      step();
      send_tlp(1'b0, 3, 64'hD0, 1'b0, 1'b0, 1'b0, 3);
      drain();
      check("post_rst_tlps", order_q.size(), 1);
      check("post_rst_app_cnt", tx_app_cnt, app_cnt_exp);
      check("post_rst_inj_cnt", tx_inj_cnt, inj_cnt_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Merges the two transmit TLP sources onto the single AXI4-Stream transmit port of the 7-series PCIe core. One source is the on-board PIO engine, which requests the bus with `pcie_tx_req` and waits for `pcie_tx_ack`. The other is the Ethernet inject path, which presents TLPs directly on a stream. The block answers the engine's request/acknowledge handshake, arbitrates per TLP with round-robin fairness, and drives the core through a 2-entry skid register so the core's `tready` has no combinational path back to either source.

## Interface
- `C_DATA_WIDTH`, default 64: TX data width.
- `KEEP_WIDTH`, default `C_DATA_WIDTH/8`: byte-enable width.
- `pcie_clk`  in  1  user clock from the PCIe core; the only clock.
- `pcie_rst_n`  in  1  reset, asynchronous assert, active-low.
- `pcie_tx_req`  in  1  PIO engine requests the bus for one TLP.
- `pcie_tx_ack`  out  1  grant to the PIO engine; high for the whole time the engine owns the bus.
- `pcie_tx_tready`  out  1  ready to the PIO engine stream.
- `pcie_tx_tvalid`, `pcie_tx_tlast`  in  1 each  PIO engine stream.
- `pcie_tx_tkeep`  in  `KEEP_WIDTH`  PIO engine stream.
- `pcie_tx_tdata`  in  `C_DATA_WIDTH`  PIO engine stream.
- `pcie_tx_tuser`  in  4  PIO engine stream.
- `inj_tx_tready`  out  1  ready to the inject stream.
- `inj_tx_tvalid`, `inj_tx_tlast`  in  1 each  inject stream.
- `inj_tx_tkeep`  in  `KEEP_WIDTH`  inject stream.
- `inj_tx_tdata`  in  `C_DATA_WIDTH`  inject stream.
- `inj_tx_tuser`  in  4  inject stream.
- `pcie_tx1_tready`  in  1  core TX ready.
- `pcie_tx1_tvalid`, `pcie_tx1_tlast`  out  1 each  core TX stream.
- `pcie_tx1_tkeep`  out  `KEEP_WIDTH`  core TX stream.
- `pcie_tx1_tdata`  out  `C_DATA_WIDTH`  core TX stream.
- `pcie_tx1_tuser`  out  4  core TX stream.
- `tx_app_cnt`  out  32  TLPs forwarded from the PIO engine.
- `tx_inj_cnt`  out  32  TLPs forwarded from the inject stream.

## Operation
- **FSM states:** IDLE, APP, INJ. A register `last_grant` holds APP or INJ; it resets to INJ, so the PIO engine wins the first tie.
- **Transitions out of IDLE:**
  - `pcie_tx_req` high and `inj_tx_tvalid` low -> APP.
  - `inj_tx_tvalid` high and `pcie_tx_req` low -> INJ.
  - Both high -> the source that is not `last_grant`.
  - Neither high -> stay in IDLE.
  - Entering a state sets `last_grant` to that state.
- **APP state:**
  - `pcie_tx_ack` = 1.
  - `pcie_tx_tready` = skid not full.
  - `inj_tx_tready` = 0.
  - An accepted beat with `tlast` -> IDLE and increment `tx_app_cnt`.
  - Dropping `pcie_tx_req` mid-TLP is ignored; ownership ends only on `tlast`.
- **INJ state:** mirror of APP. `inj_tx_tready` = skid not full; `pcie_tx_ack` = 0; `pcie_tx_tready` = 0. An accepted `tlast` beat -> IDLE and increment `tx_inj_cnt`.
- **IDLE state:** both readies and `pcie_tx_ack` are 0.
- **Packet atomicity:** TLPs from the two sources never interleave; the source is switched only in IDLE.
- **Skid buffer:**
  - Two entries, each holding {tdata, tkeep, tuser, tlast}.
  - "Not full" is a registered flag.
  - The head entry drives `pcie_tx1_*`; `pcie_tx1_tvalid` = entry count nonzero.
  - A beat is popped when `pcie_tx1_tvalid && pcie_tx1_tready`.
  - A push and a pop in the same cycle leave the count unchanged.
- **Output stability:** while `pcie_tx1_tvalid` is high and `pcie_tx1_tready` is low, all `pcie_tx1_*` outputs hold stable.
- **Counters:** 32-bit, wrap from 0xFFFFFFFF to 0, and increment on input-side acceptance of a `tlast` beat.
- **Reset:** asynchronous. A TLP in flight is discarded, including any partial beats in the skid buffer. The core is in reset in the same window.

## Timing
- **Reset values:** FSM = IDLE, skid empty, `pcie_tx_ack` = 0, both source readies = 0, all `pcie_tx1_*` outputs = 0, both counters = 0.
- **Grant latency:** a request seen in IDLE at edge N enters APP at N. `pcie_tx_ack` and `pcie_tx_tready` are high in cycle N+1.
- **Data latency:** a beat accepted at edge N is on `pcie_tx1_*` in cycle N+1 if the skid was empty.
- **Throughput:** 1 beat/cycle within a TLP while `pcie_tx1_tready` stays high.
- **Inter-packet gap:** 1 IDLE cycle at the input side after every `tlast`. The output may stay valid across that gap.
- **Ack release:** `pcie_tx_ack` falls the cycle after the accepted `tlast` beat.

## Test plan
- **Single PIO TLP:** `pcie_tx_req`=1, 3-beat TLP with tdata 0x11, 0x22, 0x33 and `pcie_tx1_tready`=1 -> `pcie_tx_ack` rises 1 cycle after req. Beats appear 1 cycle after acceptance, `tlast` on 0x33. `pcie_tx_ack` drops the next cycle; `tx_app_cnt`=1.
- **Simultaneous request, fresh from reset:** `pcie_tx_req` and `inj_tx_tvalid` both high continuously, 2-beat TLPs -> order on the core is APP, INJ, APP, INJ. No interleaved beats; after 4 TLPs both counters = 2.
- **Backpressure:** `pcie_tx1_tready` held 0 for 5 cycles during a 4-beat inject TLP -> `inj_tx_tready` falls after 2 beats. `pcie_tx1_*` hold stable. After release, all 4 beats are delivered in order with none lost or duplicated.
- **Req dropped mid-TLP:** `pcie_tx_req` deasserted after beat 1 of 3 -> `pcie_tx_ack` stays high until beat 3 (`tlast`) is accepted. The inject source is not granted before then.
- **Counter wrap:** force `tx_inj_cnt`=0xFFFFFFFF, send 1 inject TLP -> `tx_inj_cnt`=0.
- **Reset mid-TLP:** `pcie_rst_n`=0 after beat 2 of 4 -> all outputs are 0 immediately (asynchronous). After release the FSM is IDLE, the skid is empty, and the next TLP is forwarded intact.
